// File: rtl/arbitro_demx.sv
// Round-robin arbiter and sequencer for a 4:1 data selector.
// Registers grant/select, zeroes the output while idle, and limits each slot to QUANTUM cycles under contention.
module arbitro_demx #(
  parameter int ANCHO   = 4,
  parameter int QUANTUM = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [3:0]       i_Req,
  input  logic [ANCHO-1:0] i_Datos_0,
  input  logic [ANCHO-1:0] i_Datos_1,
  input  logic [ANCHO-1:0] i_Datos_2,
  input  logic [ANCHO-1:0] i_Datos_3,
  output logic [3:0]       o_Gnt,
  output logic [1:0]       o_Sel,
  output logic             o_Valido,
  output logic [ANCHO-1:0] o_Salida
);

  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QUANTUM - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ult, ult_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    sel_nxt;
  logic          valido_nxt;

  logic [1:0]    pick;
  logic          otros;
  logic          tomar;

  // Search starts just after the last owner, so the last owner is always checked last.
  always_comb begin
    logic [1:0] idx;
    logic       hallado;
    pick    = ult;
    hallado = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(int'(ult) + k);
      if (!hallado && i_Req[idx]) begin
        pick    = idx;
        hallado = 1'b1;
      end
    end
  end

  assign otros = |(i_Req & ~(4'b0001 << ult));

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt  = state;
    ult_nxt    = ult;
    cnt_nxt    = cnt;
    gnt_nxt    = o_Gnt;
    sel_nxt    = o_Sel;
    valido_nxt = o_Valido;
    tomar      = 1'b0;

    case (state)
      IDLE: begin
        if (|i_Req) tomar = 1'b1;
      end
      SERVE: begin
        if (!i_Req[ult]) begin
          if (otros) begin
            tomar = 1'b1;
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = 4'b0000;
            valido_nxt = 1'b0;
          end
        end else if (cnt == '0) begin
          if (otros) tomar = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tomar) begin
      state_nxt  = SERVE;
      ult_nxt    = pick;
      sel_nxt    = pick;
      gnt_nxt    = 4'b0001 << pick;
      valido_nxt = 1'b1;
      cnt_nxt    = RELOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      ult      <= 2'd3;
      cnt      <= '0;
      o_Gnt    <= 4'b0000;
      o_Sel    <= 2'd0;
      o_Valido <= 1'b0;
    end else begin
      state    <= state_nxt;
      ult      <= ult_nxt;
      cnt      <= cnt_nxt;
      o_Gnt    <= gnt_nxt;
      o_Sel    <= sel_nxt;
      o_Valido <= valido_nxt;
    end
  end

  // Output mux follows source data combinationally from the registered select.
  always_comb begin
    o_Salida = '0;
    if (o_Valido) begin
      case (o_Sel)
        2'd0: o_Salida = i_Datos_0;
        2'd1: o_Salida = i_Datos_1;
        2'd2: o_Salida = i_Datos_2;
        2'd3: o_Salida = i_Datos_3;
        default: o_Salida = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_demx.sv
// Self-checking bench for arbitro_demx: directed scenarios plus randomized traffic
// compared against a slot-counting round-robin reference model.
module tb_arbitro_demx;

  localparam int ANCHO   = 4;
  localparam int QUANTUM = 4;

  logic             i_Clk;
  logic             i_Rst;
  logic [3:0]       i_Req;
  logic [ANCHO-1:0] datos [4];
  logic [3:0]       o_Gnt;
  logic [1:0]       o_Sel;
  logic             o_Valido;
  logic [ANCHO-1:0] o_Salida;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 when idle), last granted index, cycles held so far.
  int m_owner;
  int m_last;
  int m_used;

  arbitro_demx #(.ANCHO(ANCHO), .QUANTUM(QUANTUM)) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Req     (i_Req),
    .i_Datos_0 (datos[0]),
    .i_Datos_1 (datos[1]),
    .i_Datos_2 (datos[2]),
    .i_Datos_3 (datos[3]),
    .o_Gnt     (o_Gnt),
    .o_Sel     (o_Sel),
    .o_Valido  (o_Valido),
    .o_Salida  (o_Salida)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] req, input logic rst);
    logic [3:0] mine;
    logic       others;
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_used  = 0;
      return;
    end
    mine   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    others = |(req & ~mine);
    if (m_owner < 0) begin
      if (req != 4'b0000) begin
        m_owner = rr_pick(req, m_last);
        m_last  = m_owner;
        m_used  = 1;
      end
    end else if (!req[m_owner] || (m_used >= QUANTUM && others)) begin
      if (others) begin
        m_owner = rr_pick(req, m_last);
        m_last  = m_owner;
        m_used  = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_used++;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then settle before sampling.
  task automatic tick(input logic [3:0] req, input logic rst);
    i_Req = req;
    i_Rst = rst;
    @(posedge i_Clk);
    model_step(req, rst);
    #1;
  endtask

  task automatic set_data();
    datos[0] = 4'b0101;
    datos[1] = 4'b0010;
    datos[2] = 4'b0011;
    datos[3] = 4'b0100;
  endtask

  task automatic test_reset();
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    checks++;
    if (o_Gnt !== 4'b0000 || o_Sel !== 2'd0 || o_Valido !== 1'b0 || o_Salida !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values got gnt=%b sel=%0d val=%b sal=%b want 0000/0/0/0000",
               o_Gnt, o_Sel, o_Valido, o_Salida);
    end
    for (int c = 0; c < 5; c++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (o_Gnt !== 4'b0000 || o_Valido !== 1'b0 || o_Salida !== 4'b0000) begin
        errors++;
        $display("FAIL idle_no_req cycle %0d got gnt=%b val=%b sal=%b want 0000/0/0000",
                 c, o_Gnt, o_Valido, o_Salida);
      end
    end
  endtask

  task automatic test_single_owner();
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b0);
    checks++;
    if (o_Gnt !== 4'b0100 || o_Sel !== 2'd2 || o_Salida !== 4'b0011) begin
      errors++;
      $display("FAIL single_grant got gnt=%b sel=%0d sal=%b want 0100/2/0011", o_Gnt, o_Sel, o_Salida);
    end
    datos[2] = 4'b1001;
    #1;
    checks++;
    if (o_Salida !== 4'b1001) begin
      errors++;
      $display("FAIL data_comb got %b want 1001", o_Salida);
    end
    datos[2] = 4'b0011;
    #1;
    for (int c = 0; c < 20; c++) begin
      tick(4'b0100, 1'b0);
      checks++;
      if (o_Gnt !== 4'b0100 || o_Valido !== 1'b1 || o_Salida !== 4'b0011) begin
        errors++;
        $display("FAIL single_hold cycle %0d got gnt=%b val=%b sal=%b want 0100/1/0011",
                 c, o_Gnt, o_Valido, o_Salida);
      end
    end
  endtask

  task automatic test_pair_quantum();
    tick(4'b0000, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      logic [1:0] want;
      tick(4'b0101, 1'b0);
      want = (((c - 1) / QUANTUM) % 2 == 0) ? 2'd0 : 2'd2;
      checks++;
      if (o_Valido !== 1'b1 || o_Sel !== want || o_Gnt !== (4'b0001 << want)) begin
        errors++;
        $display("FAIL pair_rotate cycle %0d got sel=%0d gnt=%b val=%b want sel=%0d val=1",
                 c, o_Sel, o_Gnt, o_Valido, want);
      end
    end
  endtask

  task automatic test_all_rotate();
    tick(4'b0000, 1'b1);
    for (int c = 1; c <= 5 * QUANTUM; c++) begin
      int want;
      tick(4'b1111, 1'b0);
      want = ((c - 1) / QUANTUM) % 4;
      checks++;
      if (o_Sel !== 2'(want) || o_Gnt !== (4'b0001 << want) || o_Salida !== datos[want]) begin
        errors++;
        $display("FAIL all_rotate cycle %0d got sel=%0d gnt=%b sal=%b want sel=%0d sal=%b",
                 c, o_Sel, o_Gnt, o_Salida, want, datos[want]);
      end
    end
  endtask

  task automatic test_release();
    tick(4'b0000, 1'b1);
    tick(4'b0010, 1'b0);
    tick(4'b1010, 1'b0);
    checks++;
    if (o_Sel !== 2'd1 || o_Valido !== 1'b1) begin
      errors++;
      $display("FAIL release_owner got sel=%0d val=%b want 1/1", o_Sel, o_Valido);
    end
    tick(4'b1000, 1'b0);
    checks++;
    if (o_Sel !== 2'd3 || o_Gnt !== 4'b1000 || o_Valido !== 1'b1) begin
      errors++;
      $display("FAIL release_switch got sel=%0d gnt=%b val=%b want 3/1000/1", o_Sel, o_Gnt, o_Valido);
    end
    tick(4'b0000, 1'b0);
    checks++;
    if (o_Gnt !== 4'b0000 || o_Valido !== 1'b0 || o_Salida !== 4'b0000) begin
      errors++;
      $display("FAIL release_idle got gnt=%b val=%b sal=%b want 0000/0/0000", o_Gnt, o_Valido, o_Salida);
    end
    // The released owner re-requesting alongside another source is searched last.
    tick(4'b1001, 1'b0);
    checks++;
    if (o_Sel !== 2'd0 || o_Gnt !== 4'b0001) begin
      errors++;
      $display("FAIL release_last got sel=%0d gnt=%b want 0/0001", o_Sel, o_Gnt);
    end
  endtask

  task automatic test_reset_mid();
    tick(4'b0000, 1'b1);
    tick(4'b1000, 1'b0);
    tick(4'b1001, 1'b0);
    checks++;
    if (o_Sel !== 2'd3 || o_Valido !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_owner got sel=%0d val=%b want 3/1", o_Sel, o_Valido);
    end
    tick(4'b1001, 1'b1);
    checks++;
    if (o_Gnt !== 4'b0000 || o_Valido !== 1'b0 || o_Salida !== 4'b0000 || o_Sel !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_zero got gnt=%b sel=%0d val=%b sal=%b want 0000/0/0/0000",
               o_Gnt, o_Sel, o_Valido, o_Salida);
    end
    tick(4'b1001, 1'b0);
    checks++;
    if (o_Gnt !== 4'b0001 || o_Sel !== 2'd0 || o_Valido !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_regrant got gnt=%b sel=%0d val=%b want 0001/0/1", o_Gnt, o_Sel, o_Valido);
    end
  endtask

  task automatic test_random();
    logic [3:0] req;
    int         run;
    tick(4'b0000, 1'b1);
    req = 4'b0000;
    run = 0;
    for (int c = 0; c < 400; c++) begin
      logic       rst;
      logic [3:0] want_gnt;
      logic [3:0] want_sal;
      if (run == 0) begin
        req = 4'($urandom_range(0, 15));
        run = $urandom_range(1, 8);
      end
      run--;
      if ($urandom_range(0, 3) == 0) datos[$urandom_range(0, 3)] = 4'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      tick(req, rst);
      want_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      want_sal = (m_owner >= 0) ? datos[m_owner] : 4'b0000;
      checks++;
      if (o_Gnt !== want_gnt || o_Valido !== (m_owner >= 0) || o_Salida !== want_sal ||
          (m_owner >= 0 && o_Sel !== 2'(m_owner))) begin
        errors++;
        $display("FAIL random cycle %0d req=%b got gnt=%b sel=%0d val=%b sal=%b want gnt=%b val=%b sal=%b",
                 c, req, o_Gnt, o_Sel, o_Valido, o_Salida, want_gnt, (m_owner >= 0), want_sal);
      end
    end
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_Req   = 4'b0000;
    m_owner = -1;
    m_last  = 3;
    m_used  = 0;
    set_data();
    test_reset();
    test_single_owner();
    test_pair_quantum();
    test_all_rotate();
    test_release();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_demx.md
# arbitro_demx

Round-robin arbiter and sequencer for the 4:1, 4-bit data selector: four requesters share one output bus, and the block decides which source is steered through. It registers the grant and the select, forces the output to zero while idle, and bounds each owner's slot to a quantum when other requesters are waiting. It sits directly in front of the selector datapath and replaces the hand-driven select used in simulation.

## Interface
- ANCHO, 4, data width of every source and of the output.
- QUANTUM, 4, number of cycles an owner may hold the bus while another requester is pending; legal range is 1..16.

- i_Clk, input, 1, rising-edge clock.
- i_Rst, input, 1, reset; synchronous, active-high.
- i_Req, input, 4, request flags; bit n belongs to source n and is level-sensitive.
- i_Datos_0 .. i_Datos_3, input, ANCHO each, source data.
- o_Gnt, output, 4, registered grant; one-hot or zero.
- o_Sel, output, 2, registered index of the current owner.
- o_Valido, output, 1, registered; high while a grant is active.
- o_Salida, output, ANCHO, i_Datos_[o_Sel] when o_Valido=1, otherwise 0; combinational from the registered select.

## Operation
- Internal state:
  - FSM with two states: IDLE and SERVE.
  - 2-bit owner pointer `ult`, the last granted index.
  - quantum counter `cnt`, width clog2(QUANTUM), minimum 1.
- Reset values:
  - state = IDLE, ult = 3, cnt = 0.
  - o_Gnt = 0, o_Sel = 0, o_Valido = 0, o_Salida = 0.
  - With ult = 3 after reset, source 0 has top priority on the first arbitration.
- Round-robin pick: search indices (ult+1), (ult+2), (ult+3), (ult+4) mod 4 and take the first one with i_Req set. The current owner is always considered last.
- "Others pending" means any i_Req bit other than the owner's bit is high.
- IDLE:
  - i_Req = 0: stay in IDLE.
  - Otherwise: go to SERVE and grant the pick (o_Gnt = 1<<pick, o_Sel = pick, o_Valido = 1, ult = pick, cnt = QUANTUM-1).
- SERVE, evaluated at each edge in priority order:
  1. i_Rst=1: reset values apply, overriding everything below.
  2. Owner's request low:
     - others pending: switch to the pick and reload cnt.
     - none pending: go to IDLE with o_Gnt = 0 and o_Valido = 0; ult keeps the released owner.
  3. Owner's request high, cnt = 0, others pending: switch to the pick and reload cnt.
  4. Otherwise: keep the owner; cnt decrements and saturates at 0.
- A lone owner keeps the bus indefinitely. Once cnt reaches 0 it stays there, so any new requester takes over at the very next edge.
- Switching between owners is back-to-back. o_Valido stays high and no idle cycle is inserted.
- A released owner that re-requests immediately still loses to any other pending source, because it is searched last.
- QUANTUM=1: with contention, ownership rotates every cycle.

## Timing
- Request latency: i_Req sampled at edge k gives o_Gnt/o_Sel/o_Valido valid after edge k.
- Data path: o_Salida follows i_Datos_[o_Sel] combinationally with zero cycles of latency. A change in source data shows up in the same cycle.
- Slot length under contention: exactly QUANTUM cycles (grant at edge g, switch at edge g+QUANTUM).
- Release latency: a request dropped before edge k means the grant is removed or moved at edge k.
- Reset asserted mid-grant: outputs are zero after that edge. The first grant after reset release follows the reset priority (source 0 first).
- o_Gnt is never multi-hot, and o_Gnt is nonzero if and only if o_Valido = 1.

## Test plan
- Reset, then i_Req=0000 for 5 cycles → o_Gnt=0000, o_Valido=0, o_Salida=0000 throughout.
- i_Datos_0..3 = 0101, 0010, 0011, 0100; only i_Req=0100 held → after one edge o_Gnt=0100, o_Sel=10, o_Salida=0011. The grant is held for 20 cycles with no switch.
- QUANTUM=4, i_Req=0101 held from cycle 0 → source 0 granted cycles 1–4, source 2 cycles 5–8, source 0 from cycle 9. o_Valido stays high with no gap.
- i_Req=1111 held → grant order 0,1,2,3,0, each for 4 cycles; o_Salida steps 0101, 0010, 0011, 0100, 0101.
- Source 1 owning, its request drops at cycle 2 of its slot while source 3 requests → o_Sel=11 after the next edge. Separately, a drop with no other requester → o_Valido=0 and o_Salida=0000 after the next edge.
- i_Rst pulsed for 1 cycle while source 3 owns, with i_Req=1001 held → outputs are zero after the reset edge, then source 0 is granted on the following edge.
